// File: rtl/tpm_spi_host_if.sv
// Request/data bus and SPI pins of the TPM SPI host.
// slave = host engine side, master = requester / link side.
interface tpm_spi_host_if;
    logic        start;
    logic        rw;
    logic [5:0]  xfer_size;
    logic [23:0] address;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        error;
    logic        spi_clk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;

    modport slave (
        input  start, rw, xfer_size, address, wr_data, wr_valid, spi_miso,
        output wr_ready, rd_data, rd_valid, busy, done, error,
        output spi_clk, spi_cs_n, spi_mosi
    );

    modport master (
        output start, rw, xfer_size, address, wr_data, wr_valid, spi_miso,
        input  wr_ready, rd_data, rd_valid, busy, done, error,
        input  spi_clk, spi_cs_n, spi_mosi
    );
endinterface

// File: rtl/tpm_spi_host.sv
// TPM SPI-protocol initiator: header, wait-state polling, data phase.
// Define TPM_SPI_HOST_WAIT_LIMIT_EN to abort after MAX_WAIT poll bytes.
module tpm_spi_host #(
    parameter int CLK_DIV  = 2,
    parameter int MAX_WAIT = 16
) (
    input logic           clock,
    input logic           reset,
    tpm_spi_host_if.slave bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(MAX_WAIT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(MAX_WAIT);
`ifdef TPM_SPI_HOST_WAIT_LIMIT_EN
    localparam logic [PW-1:0] POLL_LIM = PW'(MAX_WAIT - 1);
`endif

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, HEADER, POLL, DATA, CS_HOLD, DONE
    } state_e;

    state_e      state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic        sck_q, sck_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [2:0]  bit_q, bit_d;
    logic [5:0]  byte_q, byte_d;
    logic [PW-1:0] poll_q, poll_d;
    logic        rw_q, rw_d;
    logic [5:0]  size_q, size_d;
    logic [23:0] addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        wrr_q, wrr_d;
    logic        rdv_q, rdv_d;
    logic [7:0]  rdd_q, rdd_d;
    logic        pend_q, pend_d;

    logic        tick, byte_end, shifting, timed, enter_data;
    logic [7:0]  hdr_nxt;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        poll_d  = poll_q;
        rw_d    = rw_q;
        size_d  = size_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        err_d   = err_q;
        pend_d  = pend_q;
        rdd_d   = rdd_q;
        done_d  = 1'b0;
        wrr_d   = 1'b0;
        rdv_d   = 1'b0;
        tick       = 1'b0;
        byte_end   = 1'b0;
        enter_data = 1'b0;
        shifting = state_q inside {HEADER, POLL, DATA};
        timed    = (state_q inside {CS_SETUP, HEADER, POLL, DATA, CS_HOLD})
                   && !pend_q;

        unique case (byte_q[1:0])
            2'd0:    hdr_nxt = addr_q[23:16];
            2'd1:    hdr_nxt = addr_q[15:8];
            default: hdr_nxt = addr_q[7:0];
        endcase

        // A pending write load freezes the divider with SCK low.
        if (timed) begin
            tick  = (div_q == DIV_LAST);
            div_d = tick ? '0 : div_q + DW'(1);
        end else if (!pend_q) begin
            div_d = '0;
        end

        if (tick && shifting) begin
            if (!sck_q) begin
                sck_d = 1'b1;
                rx_d  = {rx_q[6:0], bus.spi_miso};
                if (state_q == DATA && rw_q && bit_q == 3'd7) begin
                    rdv_d = 1'b1;
                    rdd_d = {rx_q[6:0], bus.spi_miso};
                end
            end else begin
                sck_d = 1'b0;
                if (bit_q == 3'd7) begin
                    bit_d    = '0;
                    byte_end = 1'b1;
                end else begin
                    bit_d  = bit_q + 3'd1;
                    tx_d   = {tx_q[6:0], 1'b0};
                    mosi_d = tx_q[6];
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rw_d    = bus.rw;
                    size_d  = bus.xfer_size;
                    addr_d  = bus.address;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    tx_d    = {bus.rw, 1'b0, bus.xfer_size};
                    mosi_d  = bus.rw;
                    bit_d   = '0;
                    byte_d  = '0;
                    poll_d  = '0;
                    pend_d  = 1'b0;
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: if (tick) state_d = HEADER;
            HEADER: begin
                if (byte_end) begin
                    if (byte_q == 6'd3) begin
                        byte_d = '0;
                        if (rx_q[0]) begin
                            enter_data = 1'b1;
                        end else begin
                            state_d = POLL;
                            tx_d    = '0;
                            mosi_d  = 1'b0;
                        end
                    end else begin
                        byte_d = byte_q + 6'd1;
                        tx_d   = hdr_nxt;
                        mosi_d = hdr_nxt[7];
                    end
                end
            end
            POLL: begin
                if (byte_end) begin
                    tx_d   = '0;
                    mosi_d = 1'b0;
                    if (rx_q[0]) begin
                        enter_data = 1'b1;
                    end else begin
                        if (poll_q != POLL_MAX) poll_d = poll_q + PW'(1);
`ifdef TPM_SPI_HOST_WAIT_LIMIT_EN
                        if (poll_q == POLL_LIM) begin
                            state_d = CS_HOLD;
                            err_d   = 1'b1;
                        end
`endif
                    end
                end
            end
            DATA: begin
                if (pend_q && bus.wr_valid) begin
                    tx_d   = bus.wr_data;
                    mosi_d = bus.wr_data[7];
                    wrr_d  = 1'b1;
                    pend_d = 1'b0;
                end
                if (byte_end) begin
                    if (byte_q == size_q) begin
                        state_d = CS_HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        byte_d = byte_q + 6'd1;
                        pend_d = !rw_q;
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (enter_data) begin
            state_d = DATA;
            tx_d    = '0;
            mosi_d  = 1'b0;
            pend_d  = !rw_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            poll_q  <= '0;
            rw_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wrr_q   <= 1'b0;
            rdv_q   <= 1'b0;
            rdd_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            poll_q  <= poll_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wrr_q   <= wrr_d;
            rdv_q   <= rdv_d;
            rdd_q   <= rdd_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.spi_clk  = sck_q;
    assign bus.spi_cs_n = cs_n_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wr_ready = wrr_q;
    assign bus.rd_valid = rdv_q;
    assign bus.rd_data  = rdd_q;
`ifdef TPM_SPI_HOST_WAIT_LIMIT_EN
    assign bus.error    = err_q;
`else
    assign bus.error    = 1'b0;
`endif
endmodule

// File: tb/tb_tpm_spi_host.sv
// Bench for tpm_spi_host: TPM-side SPI model plus queued expectations.
// Build with TPM_SPI_HOST_WAIT_LIMIT_EN to exercise the poll abort path.
module tb_tpm_spi_host;
    logic clock = 1'b0;
    logic reset;

    tpm_spi_host_if bus();

    tpm_spi_host #(.CLK_DIV(2), .MAX_WAIT(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int ncmp = 0;
    int nerr = 0;
    int rises = 0, done_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    int b_r, b_d, b_w, b_rd, b_m;
    logic [7:0] miso_q[$];
    logic [7:0] mosi_got[$];
    logic [7:0] exp_rd[$];
    logic [7:0] exp_mosi[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] next_miso();
        if (miso_q.size() > 0) return miso_q.pop_front();
        return 8'h00;
    endfunction

    // TPM model: MSB-first, shifts MISO on SCK fall, captures MOSI on rise
    logic [7:0] m_byte = 8'h00;
    int         m_bit = 7;
    logic       m_cs = 1'b1;
    logic       m_sck = 1'b0;
    logic [7:0] r_sh = 8'h00;
    int         r_bits = 0;

    always @(bus.spi_cs_n or bus.spi_clk) begin
        if (bus.spi_cs_n !== m_cs) begin
            m_cs = bus.spi_cs_n;
            if (bus.spi_cs_n === 1'b0) begin
                m_byte = next_miso();
                m_bit  = 7;
                r_bits = 0;
            end
        end
        if (bus.spi_clk !== m_sck) begin
            m_sck = bus.spi_clk;
            if (bus.spi_cs_n === 1'b0 && m_sck === 1'b1) begin
                rises++;
                r_sh = {r_sh[6:0], bus.spi_mosi};
                r_bits++;
                if (r_bits == 8) begin
                    mosi_got.push_back(r_sh);
                    r_bits = 0;
                end
            end else if (bus.spi_cs_n === 1'b0 && m_sck === 1'b0) begin
                if (m_bit == 0) begin
                    m_byte = next_miso();
                    m_bit  = 7;
                end else begin
                    m_bit--;
                end
            end
        end
        bus.spi_miso = m_byte[m_bit[2:0]];
    end

    always @(negedge clock) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.wr_ready === 1'b1) wr_cnt++;
        if (bus.rd_valid === 1'b1) begin
            rd_cnt++;
            if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
            else chk("rd_data", bus.rd_data, exp_rd.pop_front());
        end
    end

    task automatic snap();
        b_r  = rises;
        b_d  = done_cnt;
        b_w  = wr_cnt;
        b_rd = rd_cnt;
        b_m  = mosi_got.size();
    endtask

    task automatic start_txn(input logic rw_v, input logic [5:0] sz,
                             input logic [23:0] a);
        @(negedge clock);
        bus.rw        = rw_v;
        bus.xfer_size = sz;
        bus.address   = a;
        bus.start     = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) seen = 1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_mosi(input string tag);
        chk({tag, "_nbytes"}, mosi_got.size() - b_m, exp_mosi.size());
        for (int i = 0; i < exp_mosi.size(); i++)
            if (b_m + i < mosi_got.size())
                chk(tag, mosi_got[b_m + i], exp_mosi[i]);
        exp_mosi.delete();
    endtask

    initial begin
        bit seen;
        bit hi;
        int r0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.rw        = 1'b0;
        bus.xfer_size = '0;
        bus.address   = '0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_cs_n", bus.spi_cs_n, 1);
        chk("rst_sck", bus.spi_clk, 0);
        chk("rst_mosi", bus.spi_mosi, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // read, no wait states
        miso_q   = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_rd   = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_mosi = '{8'h83, 8'hD4, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        snap();
        start_txn(1'b1, 6'd3, 24'hD40F00);
        wait_done("t1");
        check_mosi("t1_mosi");
        chk("t1_rises", rises - b_r, 64);
        chk("t1_rd_cnt", rd_cnt - b_rd, 4);
        chk("t1_done_cnt", done_cnt - b_d, 1);
        chk("t1_error", bus.error, 0);
        chk("t1_busy", bus.busy, 0);
        chk("t1_cs_n", bus.spi_cs_n, 1);
        chk("t1_sb_empty", exp_rd.size(), 0);

        // write with two wait states
        miso_q       = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        exp_mosi     = '{8'h00, 8'hD4, 8'h00, 8'h18, 8'h00, 8'h00, 8'hA5};
        bus.wr_data  = 8'hA5;
        bus.wr_valid = 1'b1;
        snap();
        start_txn(1'b0, 6'd0, 24'hD40018);
        wait_done("t2");
        bus.wr_valid = 1'b0;
        check_mosi("t2_mosi");
        chk("t2_rises", rises - b_r, 56);
        chk("t2_wr_cnt", wr_cnt - b_w, 1);
        chk("t2_rd_cnt", rd_cnt - b_rd, 0);
        chk("t2_done_cnt", done_cnt - b_d, 1);

        // write stall before the second data byte
        miso_q.delete();
        miso_q       = '{8'h00, 8'h00, 8'h00, 8'h01};
        exp_mosi     = '{8'h01, 8'hD4, 8'h00, 8'h24, 8'h3C, 8'h5A};
        bus.wr_data  = 8'h3C;
        bus.wr_valid = 1'b1;
        snap();
        start_txn(1'b0, 6'd1, 24'hD40024);
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clock);
            if (bus.wr_ready === 1'b1) seen = 1;
        end
        chk("t4_first_wr_ready", seen, 1);
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h5A;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clock);
            if (rises - b_r >= 40) seen = 1;
        end
        chk("t4_reach_byte2", seen, 1);
        repeat (6) @(negedge clock);
        r0 = rises;
        hi = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.spi_clk !== 1'b0) hi = 1;
        end
        chk("t4_stall_sck_low", hi, 0);
        chk("t4_stall_no_edges", rises - r0, 0);
        bus.wr_valid = 1'b1;
        wait_done("t4");
        bus.wr_valid = 1'b0;
        check_mosi("t4_mosi");
        chk("t4_rises", rises - b_r, 48);
        chk("t4_wr_cnt", wr_cnt - b_w, 2);
        chk("t4_done_cnt", done_cnt - b_d, 1);

        // start while busy and in the done cycle are both ignored
        miso_q.delete();
        miso_q   = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h5C};
        exp_rd   = '{8'h5C};
        exp_mosi = '{8'h80, 8'hD4, 8'h00, 8'h00, 8'h00};
        snap();
        start_txn(1'b1, 6'd0, 24'hD40000);
        repeat (20) @(negedge clock);
        start_txn(1'b0, 6'd5, 24'h123456);
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                seen = 1;
                bus.start = 1'b1;
            end
        end
        chk("t5_done_seen", seen, 1);
        @(negedge clock);
        bus.start = 1'b0;
        chk("t5_start_at_done_ignored", bus.busy, 0);
        repeat (100) @(negedge clock);
        chk("t5_busy_idle", bus.busy, 0);
        chk("t5_cs_n_idle", bus.spi_cs_n, 1);
        chk("t5_done_cnt", done_cnt - b_d, 1);
        chk("t5_rises", rises - b_r, 40);
        chk("t5_rd_cnt", rd_cnt - b_rd, 1);
        check_mosi("t5_mosi");

`ifdef TPM_SPI_HOST_WAIT_LIMIT_EN
        // wait limit: TPM never ready
        miso_q.delete();
        exp_mosi = '{8'h82, 8'hD4, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        snap();
        start_txn(1'b1, 6'd2, 24'hD40004);
        wait_done("t3");
        check_mosi("t3_mosi");
        chk("t3_rises", rises - b_r, 64);
        chk("t3_error", bus.error, 1);
        chk("t3_done_cnt", done_cnt - b_d, 1);
        chk("t3_rd_cnt", rd_cnt - b_rd, 0);
        chk("t3_wr_cnt", wr_cnt - b_w, 0);
        chk("t3_cs_n", bus.spi_cs_n, 1);
        miso_q       = '{8'h00, 8'h00, 8'h00, 8'h01};
        exp_mosi     = '{8'h00, 8'hD4, 8'h00, 8'h08, 8'h99};
        bus.wr_data  = 8'h99;
        bus.wr_valid = 1'b1;
        snap();
        start_txn(1'b0, 6'd0, 24'hD40008);
        wait_done("t3b");
        bus.wr_valid = 1'b0;
        check_mosi("t3b_mosi");
        chk("t3b_error_cleared", bus.error, 0);
        chk("t3b_wr_cnt", wr_cnt - b_w, 1);
`else
        // polling runs past MAX_WAIT when no limit is built in
        miso_q.delete();
        miso_q   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h01, 8'h66};
        exp_rd   = '{8'h66};
        exp_mosi = '{8'h80, 8'hD4, 8'h00, 8'h04, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        snap();
        start_txn(1'b1, 6'd0, 24'hD40004);
        wait_done("t3");
        check_mosi("t3_mosi");
        chk("t3_rises", rises - b_r, 88);
        chk("t3_error", bus.error, 0);
        chk("t3_rd_cnt", rd_cnt - b_rd, 1);
        chk("t3_done_cnt", done_cnt - b_d, 1);
`endif

        // reset during the data phase
        miso_q.delete();
        miso_q   = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_rd   = '{8'h11};
        snap();
        start_txn(1'b1, 6'd3, 24'hD40F00);
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clock);
            if (rises - b_r >= 40) seen = 1;
        end
        chk("t6_reach_data", seen, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_cs_n", bus.spi_cs_n, 1);
        chk("t6_sck", bus.spi_clk, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_mosi", bus.spi_mosi, 0);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        chk("t6_no_done", done_cnt - b_d, 0);
        chk("t6_sb_empty", exp_rd.size(), 0);
        miso_q.delete();
        miso_q   = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h7E};
        exp_rd   = '{8'h7E};
        exp_mosi = '{8'h80, 8'hD4, 8'h0F, 8'h04, 8'h00};
        snap();
        start_txn(1'b1, 6'd0, 24'hD40F04);
        wait_done("t6b");
        check_mosi("t6b_mosi");
        chk("t6b_rises", rises - b_r, 40);
        chk("t6b_rd_cnt", rd_cnt - b_rd, 1);
        chk("t6b_done_cnt", done_cnt - b_d, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
